// File: rtl/cond_flags_unit.sv
// cond_flags_unit: NZCV flag register, condition evaluation and write gating
module cond_flags_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cond,
  input  logic [1:0] flag_write,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       pc_src_in,
  input  logic       reg_write_in,
  input  logic       mem_write_in,
  input  logic       no_write,
  input  logic       flags_save,
  input  logic       flags_restore,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic [3:0] flags,
  output logic       carry_to_alu
);
  logic [3:0] shadow;
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  assign carry_to_alu = c;
  assign pc_src    = pc_src_in & cond_ex;
  assign reg_write = reg_write_in & cond_ex & ~no_write;
  assign mem_write = mem_write_in & cond_ex;
  // condition field against the registered (old) flags
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // flag and shadow registers; restore beats conditional ALU write, save and restore together swap
  always_ff @(posedge clk) begin
    if (reset) begin
      flags  <= 4'b0000;
      shadow <= 4'b0000;
    end else if (en) begin
      if (flags_save) shadow <= flags;
      if (flags_restore) flags <= shadow;
      else if (cond_ex) begin
        if (flag_write[1]) flags[3:2] <= {alu_n, alu_z};
        if (flag_write[0]) flags[1:0] <= {alu_c, alu_v};
      end
    end
  end
endmodule
